spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Byte-stream front end for the SPI master/slave pair, sitting directly upstream of it. Accepts transmit bytes on a valid/ready stream, buffers them in a small FIFO, and sequences one master transfer per byte using the master's start/busy handshake. Returns each byte the master received on a valid/ready output stream, preserving burst framing through a `last` flag.

## Interface
Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- START_TIMEOUT, 4, cycles allowed from `master_start` to `master_busy` high.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  upstream byte valid.
- tx_ready  out  1  FIFO not full.
- tx_data  in  8  byte to transmit.
- tx_last  in  1  final byte of burst.
- rx_valid  out  1  received byte valid.
- rx_ready  in  1  downstream accepts byte.
- rx_data  out  8  byte captured from `master_data_out`.
- rx_last  out  1  copy of `tx_last` for the byte that produced `rx_data`.
- master_start  out  1  one-cycle start pulse to the SPI master.
- master_data_in  out  8  byte to shift out.
- master_busy  in  1  master transfer in progress.
- master_data_out  in  8  byte shifted in by the master.
- idle  out  1  FIFO empty, FSM in IDLE, rx register empty.
- timeout_err  out  1  sticky; busy never rose within START_TIMEOUT.

## Operation
- Write into the TX FIFO on `tx_valid && tx_ready`. Each entry holds {last, data}, 9 bits.
- FSM states: IDLE, START, WAIT_BUSY, XFER, CAPTURE.
- IDLE → START when FIFO is non-empty and the rx register is empty or being drained this cycle. Pop the FIFO head into `cur_data`/`cur_last`.
- START: assert `master_start` for exactly one cycle and drive `master_data_in = cur_data`. Go to WAIT_BUSY. Clear the timeout counter.
- WAIT_BUSY: on `master_busy` = 1, go to XFER. Otherwise increment the counter; when it reaches START_TIMEOUT, set `timeout_err`, drop the byte, and return to IDLE.
- XFER: on `master_busy` = 0, go to CAPTURE.
- CAPTURE: load the rx register with {`cur_last`, `master_data_out`} and set `rx_valid`. Return to IDLE.
- rx register: single entry. `rx_valid` holds until `rx_valid && rx_ready`.
- No new transfer starts while the rx register is full, so received bytes are never lost.
- `master_data_in` stays equal to `cur_data` from START until leaving XFER. It holds its value in IDLE.
- Simultaneous FIFO push and pop is legal when the FIFO is full only if the pop happens that cycle. `tx_ready` depends on the registered count only, not on the pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- `timeout_err` is cleared only by `rst`.

## Timing
- Reset values: tx_ready=1, rx_valid=0, rx_data=0, rx_last=0, master_start=0, master_data_in=0, idle=1, timeout_err=0. FSM is IDLE and the FIFO is empty.
- Reset mid-transfer abandons the byte and flushes the FIFO. The master is reset by the same `rst` net.
- Byte accepted at cycle N → `master_start` high at cycle N+2 (FIFO write at N, IDLE sees non-empty at N+1, START at N+2).
- CAPTURE at cycle M → `rx_valid` high at M+1.
- Back-to-back bytes: the next START follows CAPTURE by 2 cycles (IDLE → START) when the rx register is drained in the same cycle.
- All outputs are registered. There are no combinational paths from rx_ready or tx_valid to outputs.

## Structure
- Package `spi_pkg`: the `spi_burst_state_e` enum (5 states) and a `SPI_BYTE_W = 8` constant.
- Sub-module `spi_byte_fifo`: parameterised synchronous FIFO with width and depth parameters and full/empty/count outputs, instantiated once for TX.
- The FSM, timeout counter and rx register live in the top module.

## Test plan
- Single byte 0xA5 with last=1, slave_data_in=0x3C → one `master_start` pulse; rx_data=0x3C, rx_last=1; `idle` returns to 1.
- Burst 0x01,0x02,0x03,0x04 (last on 0x04) with rx_ready=1 → four start pulses in order and four rx bytes; only the fourth has rx_last=1.
- Push 5 bytes with FIFO_DEPTH=4 while rx_ready=0 → `tx_ready`=0 once 4 bytes are buffered. Only one transfer completes until rx_ready rises; no byte is lost or duplicated.
- Model a master that never raises busy → `timeout_err`=1 at START+1+START_TIMEOUT cycles. FSM is back in IDLE and the next byte is still processed.
- Assert `rst` during XFER with 2 bytes queued → next cycle: FIFO empty, rx_valid=0, idle=1, master_start=0.
- Push while popping at FIFO full → count stays at 4 and data order is preserved.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI burst front end: FSM state encoding and TX FIFO entry layout.
// Latency: none (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_XFER,
    ST_CAPTURE
  } spi_burst_state_e;

  // One buffered transmit byte together with its burst-end marker.
  typedef struct packed {
    logic                  last;
    logic [SPI_BYTE_W-1:0] data;
  } spi_tx_entry_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Generic synchronous FIFO with full/empty/count status; head entry is visible on rd_data.
// Latency: a write is visible at the head one cycle later; a pop advances the head the next cycle.
// Backpressure: writes are ignored when full unless a pop happens in the same cycle.
module spi_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Sequences one SPI master transfer per buffered TX byte and returns received bytes with burst framing.
// Latency: byte accepted at N -> master_start at N+2; CAPTURE at M -> rx_valid at M+1.
// Backpressure: tx_ready drops when the TX FIFO is full; no transfer starts while the rx register is held.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_last,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_last,
  output logic                  master_start,
  output logic [SPI_BYTE_W-1:0] master_data_in,
  input  logic                  master_busy,
  input  logic [SPI_BYTE_W-1:0] master_data_out,
  output logic                  idle,
  output logic                  timeout_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  spi_burst_state_e      state;
  spi_burst_state_e      state_n;
  spi_tx_entry_t         fifo_din;
  spi_tx_entry_t         fifo_dout;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  pop;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  err_set;
  logic                  capture;
  logic [TW-1:0]         tmo_cnt;
  logic [TW-1:0]         tmo_cnt_inc;
  logic [SPI_BYTE_W-1:0] cur_data;
  logic                  cur_last;

  assign fifo_din    = '{last: tx_last, data: tx_data};
  assign fifo_wr_en  = tx_valid && tx_ready;
  assign tx_ready    = !fifo_full;
  assign tmo_cnt_inc = tmo_cnt + TW'(1);

  // All status outputs decode flops only, so no input reaches an output combinationally.
  assign master_start   = (state == ST_START);
  assign master_data_in = cur_data;
  assign idle           = (state == ST_IDLE) && (fifo_count == '0) && !rx_valid;

  spi_byte_fifo #(
    .WIDTH ($bits(spi_tx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_din),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    err_set = 1'b0;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        // Only start when the result has somewhere to land.
        if (!fifo_empty && (!rx_valid || rx_ready)) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        cnt_clr = 1'b1;
        state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (master_busy) begin
          state_n = ST_XFER;
        end else if (tmo_cnt_inc == TW'(START_TIMEOUT)) begin
          // Master never acknowledged: drop this byte and move on.
          err_set = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_XFER: begin
        if (!master_busy) begin
          state_n = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Current byte under transfer; also drives master_data_in and holds it while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_data <= '0;
      cur_last <= 1'b0;
    end else if (pop) begin
      cur_data <= fifo_dout.data;
      cur_last <= fifo_dout.last;
    end
  end

  // Start-to-busy timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (cnt_clr) begin
        tmo_cnt <= '0;
      end else if (cnt_inc) begin
        tmo_cnt <= tmo_cnt_inc;
      end
      if (err_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Single-entry rx register; capture only happens when it is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_last  <= 1'b0;
    end else if (capture) begin
      rx_valid <= 1'b1;
      rx_data  <= master_data_out;
      rx_last  <= cur_last;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural SPI master that returns each byte XOR 0x99.
// Latency: master raises busy the cycle after start, holds it three cycles, then presents the reply.
// Backpressure: rx_ready and the master's busy response are controlled per scenario.
module tb_spi_burst_ctrl;

  localparam logic [7:0] RESP_XOR = 8'h99;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       master_start;
  logic [7:0] master_data_in;
  logic       master_busy;
  logic [7:0] master_data_out;
  logic       idle;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       busy_en;
  logic [1:0] bcnt;
  logic [7:0] shadow;

  logic [8:0] rx_q[$];
  int         rx_cyc_q[$];
  logic [7:0] st_q[$];
  int         st_cyc_q[$];

  spi_burst_ctrl #(
    .FIFO_DEPTH    (4),
    .START_TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .tx_last         (tx_last),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .rx_last         (rx_last),
    .master_start    (master_start),
    .master_data_in  (master_data_in),
    .master_busy     (master_busy),
    .master_data_out (master_data_out),
    .idle            (idle),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPI master: busy for three cycles after a start, reply = sent byte ^ 0x99.
  always @(posedge clk) begin
    if (rst) begin
      master_busy     <= 1'b0;
      bcnt            <= 2'd0;
      master_data_out <= 8'h00;
      shadow          <= 8'h00;
    end else if (master_start && busy_en) begin
      master_busy <= 1'b1;
      bcnt        <= 2'd3;
      shadow      <= master_data_in ^ RESP_XOR;
    end else if (bcnt != 2'd0) begin
      bcnt <= bcnt - 2'd1;
      if (bcnt == 2'd1) begin
        master_busy     <= 1'b0;
        master_data_out <= shadow;
      end
    end
  end

  // Log start pulses and rx handshakes mid-cycle, where all signals are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        rx_q.push_back({rx_last, rx_data});
        rx_cyc_q.push_back(cyc);
      end
      if (master_start) begin
        st_q.push_back(master_data_in);
        st_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_cyc_q.delete();
    st_q.delete();
    st_cyc_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    bit done;
    done     = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      done = tx_ready;
      tick();
    end
    tx_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL push_accept: byte %h not accepted (got %b want 1)", d, done);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    rx_ready = 1'b0; busy_en = 1'b1;
    tick(); tick();
    n_checks++; if (tx_ready !== 1'b1)        begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_checks++; if (rx_valid !== 1'b0)        begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00)        begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_last !== 1'b0)         begin n_fail++; $display("FAIL reset_rx_last: got %b want 0", rx_last); end
    n_checks++; if (master_start !== 1'b0)    begin n_fail++; $display("FAIL reset_master_start: got %b want 0", master_start); end
    n_checks++; if (master_data_in !== 8'h00) begin n_fail++; $display("FAIL reset_master_data_in: got %h want 00", master_data_in); end
    n_checks++; if (idle !== 1'b1)            begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++; if (timeout_err !== 1'b0)     begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0;
    tick();
    n_checks++; if (idle !== 1'b1)            begin n_fail++; $display("FAIL post_reset_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    clear_logs();
    rx_ready = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_checks++; if (master_start !== 1'b0)    begin n_fail++; $display("FAIL single_start_n1: got %b want 0", master_start); end
    tick();
    n_checks++; if (master_start !== 1'b1)    begin n_fail++; $display("FAIL single_start_n2: got %b want 1", master_start); end
    n_checks++; if (master_data_in !== 8'hA5) begin n_fail++; $display("FAIL single_data_in: got %h want a5", master_data_in); end
    n_checks++; if (idle !== 1'b0)            begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", idle); end
    wait_rx(1, 40);
    tick();
    n_checks++; if (rx_q.size() !== 1)        begin n_fail++; $display("FAIL single_rx_count: got %0d want 1", rx_q.size()); end
    n_checks++; if (rx_q[0] !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL single_rx: got %h want 13c", rx_q[0]); end
    n_checks++; if (st_q.size() !== 1)        begin n_fail++; $display("FAIL single_start_count: got %0d want 1", st_q.size()); end
    n_checks++; if (idle !== 1'b1)            begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
    n_checks++; if (master_data_in !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h want a5", master_data_in); end
  endtask

  task automatic test_burst();
    logic [7:0] d;
    clear_logs();
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h01 + 8'(i), (i == 3));
    wait_rx(4, 300);
    n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL burst_rx_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      d = 8'h01 + 8'(i);
      n_checks++; if (st_q[i] !== d) begin n_fail++; $display("FAIL burst_start_%0d: got %h want %h", i, st_q[i], d); end
      n_checks++; if (rx_q[i] !== {(i == 3), d ^ RESP_XOR}) begin
        n_fail++; $display("FAIL burst_rx_%0d: got %h want %h", i, rx_q[i], {(i == 3), d ^ RESP_XOR});
      end
    end
    // Draining rx in the cycle after CAPTURE lets the next START follow immediately.
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (st_cyc_q[i+1] - rx_cyc_q[i] !== 1) begin
        n_fail++; $display("FAIL burst_gap_%0d: got %0d want 1", i, st_cyc_q[i+1] - rx_cyc_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    clear_logs();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), (i == 4));
    repeat (20) tick();
    n_checks++; if (tx_ready !== 1'b0)    begin n_fail++; $display("FAIL bp_tx_ready_full: got %b want 0", tx_ready); end
    n_checks++; if (st_q.size() !== 1)    begin n_fail++; $display("FAIL bp_one_start: got %0d want 1", st_q.size()); end
    n_checks++; if (rx_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_rx_held: got %b want 1", rx_valid); end
    n_checks++; if (rx_data !== 8'h89)    begin n_fail++; $display("FAIL bp_rx_data: got %h want 89", rx_data); end
    n_checks++; if (idle !== 1'b0)        begin n_fail++; $display("FAIL bp_idle: got %b want 0", idle); end
    rx_ready = 1'b1;
    wait_rx(5, 300);
    repeat (10) tick();
    n_checks++; if (rx_q.size() !== 5)    begin n_fail++; $display("FAIL bp_rx_count: got %0d want 5", rx_q.size()); end
    n_checks++; if (st_q.size() !== 5)    begin n_fail++; $display("FAIL bp_start_count: got %0d want 5", st_q.size()); end
    for (int i = 0; i < 5; i++) begin
      d = 8'h10 + 8'(i);
      n_checks++; if (rx_q[i] !== {(i == 4), d ^ RESP_XOR}) begin
        n_fail++; $display("FAIL bp_rx_%0d: got %h want %h", i, rx_q[i], {(i == 4), d ^ RESP_XOR});
      end
    end
    n_checks++; if (tx_ready !== 1'b1)    begin n_fail++; $display("FAIL bp_tx_ready_end: got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout();
    clear_logs();
    rx_ready = 1'b1;
    busy_en  = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    n_checks++; if (master_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", master_start); end
    repeat (4) tick();
    n_checks++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
    tick();
    n_checks++; if (timeout_err !== 1'b1)  begin n_fail++; $display("FAIL tmo_set: got %b want 1", timeout_err); end
    n_checks++; if (idle !== 1'b1)         begin n_fail++; $display("FAIL tmo_idle: got %b want 1", idle); end
    busy_en = 1'b1;
    push_byte(8'h66, 1'b1);
    wait_rx(1, 60);
    n_checks++; if (rx_q.size() !== 1)     begin n_fail++; $display("FAIL tmo_rx_count: got %0d want 1", rx_q.size()); end
    n_checks++; if (rx_q[0] !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL tmo_next_rx: got %h want 1ff", rx_q[0]); end
    n_checks++; if (st_q.size() !== 2)     begin n_fail++; $display("FAIL tmo_start_count: got %0d want 2", st_q.size()); end
    n_checks++; if (timeout_err !== 1'b1)  begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    rx_ready = 1'b1;
    busy_en  = 1'b1;
    push_byte(8'h31, 1'b0);
    push_byte(8'h32, 1'b0);
    push_byte(8'h33, 1'b1);
    for (int i = 0; i < 20 && !master_busy; i++) tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (tx_ready !== 1'b1)     begin n_fail++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (idle !== 1'b1)         begin n_fail++; $display("FAIL rstmid_idle: got %b want 1", idle); end
    n_checks++; if (master_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b want 0", master_start); end
    n_checks++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL rstmid_tmo_clear: got %b want 0", timeout_err); end
    rst = 1'b0;
    repeat (20) tick();
    n_checks++; if (st_q.size() !== 1)     begin n_fail++; $display("FAIL rstmid_flushed: got %0d starts want 1", st_q.size()); end
    n_checks++; if (rx_q.size() !== 0)     begin n_fail++; $display("FAIL rstmid_no_rx: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] d;
    clear_logs();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i), 1'b0);
    repeat (20) tick();
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_tx_ready: got %b want 0", tx_ready); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL full_rx_valid: got %b want 1", rx_valid); end
    // Offer a byte in the very cycle the head is popped: readiness follows the registered count.
    tx_valid = 1'b1; tx_data = 8'h25; tx_last = 1'b1; rx_ready = 1'b1;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle_ready: got %b want 0", tx_ready); end
    tick();
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop_ready: got %b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_refilled: got %b want 0", tx_ready); end
    wait_rx(6, 400);
    n_checks++; if (rx_q.size() !== 6) begin n_fail++; $display("FAIL full_rx_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      d = 8'h20 + 8'(i);
      n_checks++; if (rx_q[i] !== {(i == 5), d ^ RESP_XOR}) begin
        n_fail++; $display("FAIL full_rx_%0d: got %h want %h", i, rx_q[i], {(i == 5), d ^ RESP_XOR});
      end
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    rx_ready = 1'b0; busy_en = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_full_pushpop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
